// File: rtl/count_uart_tx.sv
// Snapshots an 8-bit counter on a sample strobe or on 0xFF->0x00 wrap, queues the
// snapshots in a small FIFO and sends each one as a UART 8N1 frame on tx.
module count_uart_tx #(
    parameter int CLKS_PER_BIT = 87,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          ena,
    input  logic [7:0]                    count_in,
    input  logic                          sample,
    output logic                          tx,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic                          fifo_full,
    output logic                          drop
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int LW = PW + 1;
    localparam int BW = $clog2(CLKS_PER_BIT);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    state_t          state_q, state_d;
    logic [BW-1:0]   baud_q, baud_d;
    logic [2:0]      bit_q, bit_d;
    logic [7:0]      shift_q, shift_d;
    logic            tx_q, tx_d;
    logic [7:0]      prev_q, prev_d;
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]   level_q, level_d;
    logic            drop_q, drop_d;
    logic [7:0]      mem_q [FIFO_DEPTH];
    logic [7:0]      mem_d [FIFO_DEPTH];

    logic wrap;
    logic push_req;
    logic full;
    logic push;
    logic pop;
    logic baud_last;

    // Full is judged on the current level, so a same-cycle pop never rescues a push.
    always_comb begin
        wrap      = ena && (prev_q == 8'hFF) && (count_in == 8'h00);
        push_req  = ena && (sample || wrap);
        full      = (level_q == LW'(FIFO_DEPTH));
        push      = push_req && !full;
        pop       = (state_q == IDLE) && ena && (level_q != '0);
        baud_last = (baud_q == BW'(CLKS_PER_BIT - 1));
    end

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        drop_d   = drop_q | (push_req & full);
        prev_d   = ena ? count_in : prev_q;
        if (push) begin
            mem_d[wr_ptr_q] = count_in;
            wr_ptr_d        = wr_ptr_q + PW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end
        case ({push, pop})
            2'b10:   level_d = level_q + LW'(1);
            2'b01:   level_d = level_q - LW'(1);
            default: level_d = level_q;
        endcase
    end

    always_comb begin
        state_d = state_q;
        baud_d  = baud_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        case (state_q)
            IDLE: begin
                baud_d = '0;
                bit_d  = '0;
                if (pop) begin
                    shift_d = mem_q[rd_ptr_q];
                    state_d = START;
                end
            end
            START: begin
                if (baud_last) begin
                    baud_d  = '0;
                    state_d = DATA;
                end else begin
                    baud_d = baud_q + BW'(1);
                end
            end
            DATA: begin
                if (baud_last) begin
                    baud_d  = '0;
                    shift_d = {1'b0, shift_q[7:1]};
                    if (bit_q == 3'd7) begin
                        state_d = STOP;
                    end else begin
                        bit_d = bit_q + 3'd1;
                    end
                end else begin
                    baud_d = baud_q + BW'(1);
                end
            end
            STOP: begin
                if (baud_last) begin
                    baud_d  = '0;
                    state_d = IDLE;
                end else begin
                    baud_d = baud_q + BW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // tx is registered from the next state so the pin never glitches on decode.
    always_comb begin
        tx_d = 1'b1;
        case (state_d)
            START:   tx_d = 1'b0;
            DATA:    tx_d = shift_d[0];
            default: tx_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            baud_q   <= '0;
            bit_q    <= '0;
            shift_q  <= '0;
            tx_q     <= 1'b1;
            prev_q   <= 8'h00;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            drop_q   <= 1'b0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_q[i] <= 8'h00;
            end
        end else begin
            state_q  <= state_d;
            baud_q   <= baud_d;
            bit_q    <= bit_d;
            shift_q  <= shift_d;
            tx_q     <= tx_d;
            prev_q   <= prev_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            drop_q   <= drop_d;
            mem_q    <= mem_d;
        end
    end

    assign tx         = tx_q;
    assign busy       = (state_q != IDLE);
    assign fifo_level = level_q;
    assign fifo_full  = full;
    assign drop       = drop_q;

endmodule

// File: tb/tb_count_uart_tx.sv
// Directed bench for count_uart_tx with CLKS_PER_BIT=4, FIFO_DEPTH=4; a background
// receiver decodes frames from tx into rx_q for the scenario tasks to inspect.
module tb_count_uart_tx;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       ena = 1'b0;
    logic [7:0] count_in = 8'h00;
    logic       sample = 1'b0;
    logic       tx;
    logic       busy;
    logic [2:0] fifo_level;
    logic       fifo_full;
    logic       drop;

    int checks   = 0;
    int failures = 0;
    int stop_bad = 0;
    logic [7:0] rx_q [$];

    count_uart_tx #(.CLKS_PER_BIT(4), .FIFO_DEPTH(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .ena        (ena),
        .count_in   (count_in),
        .sample     (sample),
        .tx         (tx),
        .busy       (busy),
        .fifo_level (fifo_level),
        .fifo_full  (fifo_full),
        .drop       (drop)
    );

    initial forever #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Receiver: start bit seen at cycle S, data bit i sampled at S+6+4i, stop at S+38.
    initial begin
        logic [7:0] mon_d;
        bit aborted;
        mon_d = 8'h00;
        forever begin
            @(posedge clk);
            #1;
            if (rst === 1'b0 && tx === 1'b0) begin
                aborted = 1'b0;
                for (int k = 1; k <= 38; k++) begin
                    @(posedge clk);
                    #1;
                    if (rst !== 1'b0) aborted = 1'b1;
                    if (k >= 6 && k <= 34 && ((k - 6) % 4) == 0) mon_d[3'((k - 6) / 4)] = tx;
                end
                if (!aborted) begin
                    rx_q.push_back(mon_d);
                    if (tx !== 1'b1) stop_bad++;
                end
            end
        end
    end

    task automatic wait_frames(input int n, input int budget);
        for (int i = 0; i < budget; i++) begin
            if (rx_q.size() >= n) break;
            tick();
        end
    endtask

    task automatic test_reset();
        tick();
        tick();
        #2 rst = 1'b1;
        #1;
        checks++; if (tx !== 1'b1) begin failures++; $display("FAIL reset_tx: got %b want 1", tx); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b want 0", busy); end
        checks++; if (fifo_level !== 3'd0) begin failures++; $display("FAIL reset_level: got %0d want 0", fifo_level); end
        checks++; if (fifo_full !== 1'b0) begin failures++; $display("FAIL reset_full: got %b want 0", fifo_full); end
        checks++; if (drop !== 1'b0) begin failures++; $display("FAIL reset_drop: got %b want 0", drop); end
        tick();
        tick();
        rst = 1'b0;
        repeat (3) tick();
        checks++; if (tx !== 1'b1 || busy !== 1'b0) begin failures++; $display("FAIL post_reset_idle: tx=%b busy=%b want 1/0", tx, busy); end
    endtask

    task automatic test_single_frame();
        logic [7:0] v;
        logic exp_tx;
        logic exp_busy;
        v = 8'hA5;
        rx_q.delete();
        count_in = v;
        ena = 1'b1;
        sample = 1'b1;
        tick();
        sample = 1'b0;
        for (int k = 1; k <= 42; k++) begin
            if (k >= 2 && k <= 5) exp_tx = 1'b0;
            else if (k >= 6 && k <= 37) exp_tx = v[3'((k - 6) / 4)];
            else exp_tx = 1'b1;
            exp_busy = (k >= 2 && k <= 41);
            checks++; if (tx !== exp_tx) begin failures++; $display("FAIL single_tx N+%0d: got %b want %b", k, tx, exp_tx); end
            checks++; if (busy !== exp_busy) begin failures++; $display("FAIL single_busy N+%0d: got %b want %b", k, busy, exp_busy); end
            tick();
        end
        checks++; if (rx_q.size() != 1 || rx_q[0] !== 8'hA5) begin failures++; $display("FAIL single_rx: got %0d frames want one 0xa5", rx_q.size()); end
    endtask

    task automatic test_wrap();
        for (int r = 0; r < 2; r++) begin
            rx_q.delete();
            count_in = 8'hFE; tick();
            count_in = 8'hFF; tick();
            count_in = 8'h00;
            sample = (r == 1);
            tick();
            sample = 1'b0;
            count_in = 8'h01;
            checks++; if (fifo_level !== 3'd1) begin failures++; $display("FAIL wrap_level r%0d: got %0d want 1", r, fifo_level); end
            repeat (60) tick();
            checks++; if (rx_q.size() != 1) begin failures++; $display("FAIL wrap_count r%0d: got %0d frames want 1", r, rx_q.size()); end
            else begin
                checks++; if (rx_q[0] !== 8'h00) begin failures++; $display("FAIL wrap_value r%0d: got %h want 00", r, rx_q[0]); end
            end
        end
    endtask

    task automatic test_overflow();
        rx_q.delete();
        stop_bad = 0;
        ena = 1'b1;
        for (int i = 1; i <= 6; i++) begin
            count_in = 8'(i);
            sample = 1'b1;
            if (i == 6) begin
                checks++; if (fifo_full !== 1'b1 || fifo_level !== 3'd4) begin failures++; $display("FAIL ovf_full: full=%b level=%0d want 1/4", fifo_full, fifo_level); end
                checks++; if (drop !== 1'b0) begin failures++; $display("FAIL ovf_drop_early: got %b want 0", drop); end
            end
            tick();
        end
        sample = 1'b0;
        count_in = 8'h40;
        checks++; if (drop !== 1'b1) begin failures++; $display("FAIL ovf_drop: got %b want 1", drop); end
        checks++; if (fifo_level !== 3'd4) begin failures++; $display("FAIL ovf_level: got %0d want 4", fifo_level); end
        wait_frames(5, 400);
        repeat (60) tick();
        checks++; if (rx_q.size() != 5) begin failures++; $display("FAIL ovf_count: got %0d frames want 5", rx_q.size()); end
        else begin
            for (int i = 0; i < 5; i++) begin
                checks++; if (rx_q[i] !== 8'(i + 1)) begin failures++; $display("FAIL ovf_order[%0d]: got %h want %h", i, rx_q[i], 8'(i + 1)); end
            end
        end
        checks++; if (drop !== 1'b1) begin failures++; $display("FAIL ovf_drop_sticky: got %b want 1", drop); end
        checks++; if (stop_bad != 0) begin failures++; $display("FAIL ovf_stop_bits: got %0d bad want 0", stop_bad); end
    endtask

    task automatic test_ena_gate();
        rx_q.delete();
        ena = 1'b1;
        count_in = 8'h11; sample = 1'b1; tick();
        count_in = 8'h22; tick();
        count_in = 8'h33; tick();
        sample = 1'b0;
        repeat (10) tick();
        checks++; if (busy !== 1'b1) begin failures++; $display("FAIL gate_busy_mid: got %b want 1", busy); end
        ena = 1'b0;
        count_in = 8'h44;
        sample = 1'b1;
        repeat (3) tick();
        sample = 1'b0;
        repeat (40) tick();
        checks++; if (busy !== 1'b0 || tx !== 1'b1) begin failures++; $display("FAIL gate_idle: busy=%b tx=%b want 0/1", busy, tx); end
        checks++; if (fifo_level !== 3'd2) begin failures++; $display("FAIL gate_level: got %0d want 2", fifo_level); end
        checks++; if (rx_q.size() != 1 || rx_q[0] !== 8'h11) begin failures++; $display("FAIL gate_first: got %0d frames want one 0x11", rx_q.size()); end
        ena = 1'b1;
        count_in = 8'h50;
        wait_frames(3, 300);
        repeat (20) tick();
        checks++; if (rx_q.size() != 3) begin failures++; $display("FAIL gate_count: got %0d frames want 3", rx_q.size()); end
        else begin
            checks++; if (rx_q[1] !== 8'h22 || rx_q[2] !== 8'h33) begin failures++; $display("FAIL gate_order: got %h %h want 22 33", rx_q[1], rx_q[2]); end
        end
    endtask

    task automatic test_reset_mid_frame();
        rx_q.delete();
        ena = 1'b1;
        sample = 1'b1;
        for (int i = 0; i < 4; i++) begin
            count_in = 8'h61 + 8'(i);
            tick();
        end
        sample = 1'b0;
        repeat (10) tick();
        checks++; if (fifo_level !== 3'd3 || busy !== 1'b1) begin failures++; $display("FAIL mid_pre: level=%0d busy=%b want 3/1", fifo_level, busy); end
        #2 rst = 1'b1;
        #1;
        checks++; if (tx !== 1'b1 || busy !== 1'b0) begin failures++; $display("FAIL mid_rst_line: tx=%b busy=%b want 1/0", tx, busy); end
        checks++; if (fifo_level !== 3'd0 || drop !== 1'b0) begin failures++; $display("FAIL mid_rst_fifo: level=%0d drop=%b want 0/0", fifo_level, drop); end
        tick();
        tick();
        rst = 1'b0;
        repeat (100) tick();
        checks++; if (rx_q.size() != 0) begin failures++; $display("FAIL mid_no_frame: got %0d frames want 0", rx_q.size()); end
        checks++; if (tx !== 1'b1 || busy !== 1'b0 || fifo_level !== 3'd0) begin failures++; $display("FAIL mid_quiet: tx=%b busy=%b level=%0d want 1/0/0", tx, busy, fifo_level); end
    endtask

    initial begin
        test_reset();
        test_single_frame();
        test_wrap();
        test_overflow();
        test_ena_gate();
        test_reset_mid_frame();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
